// File: rtl/btn_event_sched_if.sv
// Event handshake between the button scheduler (master) and the calculator control FSM (slave).
interface btn_event_sched_if #(
   parameter int N_BTN = 5
) ();
   localparam int CODE_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

   logic              evt_valid;
   logic              evt_ready;
   logic [CODE_W-1:0] evt_code;
   logic              evt_repeat;

   modport master (output evt_valid, output evt_code, output evt_repeat, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_repeat, output evt_ready);
endinterface

// File: rtl/btn_event_sched.sv
// Turns debounced active-low button levels into press / auto-repeat events, arbitrated by
// lowest index into a small show-ahead FIFO drained over a valid/ready handshake.
module btn_event_sched #(
   parameter int N_BTN         = 5,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_BTN-1:0]   btn_n_i,
   btn_event_sched_if.master  evt_if,
   output logic               ovf_o
);

   localparam int CODE_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam int ENT_W   = CODE_W + 1;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_BTN-1:0]  prev_q, prev_d;
   logic [N_BTN-1:0]  pend_q, pend_d;
   logic [N_BTN-1:0]  rep_q, rep_d;
   logic              ovf_q, ovf_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];

   logic [N_BTN-1:0]  held, press, tick_vec, evt, grant_vec, merge;
   logic              stable, one_held, tick;
   logic              full, empty, push, pop;
   logic [CODE_W-1:0] grant_idx;
   logic [ENT_W-1:0]  push_ent, head;

   assign held     = ~btn_n_i;
   assign press    = prev_q & held;
   assign stable   = (btn_n_i == prev_q);
   assign one_held = (held != '0) && ((held & (held - N_BTN'(1))) == '0);

   // Repeat FSM: any level change drops back to IDLE without a tick
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (stable && one_held) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end
         end
         S_HOLD: begin
            if (!stable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               tick    = 1'b1;
               cnt_d   = '0;
               state_d = S_REPEAT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REPEAT: begin
            if (!stable) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
               tick  = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Only one button can be held while in HOLD/REPEAT, so held is one-hot here
   assign tick_vec = tick ? held : '0;
   assign evt      = press | tick_vec;

   assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign pop   = !empty && evt_if.evt_ready;
   assign push  = !full && (pend_q != '0);

   always_comb begin
      grant_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (pend_q[i]) grant_idx = CODE_W'(i);
      end
   end

   assign grant_vec = push ? (pend_q & (~pend_q + N_BTN'(1))) : '0;
   assign push_ent  = {rep_q[grant_idx], grant_idx};

   // A new event on a granted button re-arms its staging slot instead of merging
   assign merge  = evt & pend_q & ~grant_vec;
   assign pend_d = (pend_q & ~grant_vec) | evt;
   assign rep_d  = (rep_q & ~evt) | tick_vec;
   assign ovf_d  = ovf_q | (merge != '0);
   assign prev_d = btn_n_i;

   assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
   assign rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         prev_q   <= '1;
         pend_q   <= '0;
         rep_q    <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prev_q   <= prev_d;
         pend_q   <= pend_d;
         rep_q    <= rep_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_ent;
   end

   assign head              = mem_q[rd_ptr_q];
   assign evt_if.evt_valid  = !empty;
   assign evt_if.evt_code   = empty ? '0 : head[CODE_W-1:0];
   assign evt_if.evt_repeat = !empty && head[CODE_W];
   assign ovf_o             = ovf_q;

endmodule

// File: tb/tb_btn_event_sched.sv
// Bench for btn_event_sched: directed scenarios plus random button/ready traffic against a queue model.
module tb_btn_event_sched;
   localparam int N = 5;
   localparam int H = 20;
   localparam int R = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] btn_n;
   logic         ovf;

   always #5 clk = ~clk;

   btn_event_sched_if #(.N_BTN(N)) evt_if ();

   btn_event_sched #(
      .N_BTN(N), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_n_i(btn_n), .evt_if(evt_if), .ovf_o(ovf)
   );

   typedef struct {bit rep; int code;} ev_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: staging flags, event queue, length of the current stable single-hold run
   logic [N-1:0] m_prev;
   bit   [N-1:0] m_pend, m_rep;
   int           m_run;
   bit           m_ovf;
   ev_t          m_q[$];
   ev_t          got[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_step(input logic [N-1:0] b, input bit r, input bit rs);
      int g;
      bit pop, tick, press, tk;
      logic [N-1:0] held;
      if (!rs) begin
         m_prev = '1; m_pend = '0; m_rep = '0; m_run = 0; m_ovf = 1'b0;
         m_q.delete();
      end else begin
         g = -1;
         if (m_q.size() < D) begin
            for (int i = 0; i < N; i++) if (m_pend[i]) begin g = i; break; end
         end
         pop  = (m_q.size() > 0) && r;
         held = ~b;
         if (b == m_prev && $countones(held) == 1) m_run++; else m_run = 0;
         tick = (m_run > H) && (((m_run - H - 1) % R) == 0);
         if (pop) void'(m_q.pop_front());
         if (g >= 0) begin
            m_q.push_back('{m_rep[g], g});
            m_pend[g] = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            press = m_prev[i] && !b[i];
            tk    = tick && held[i];
            if (press || tk) begin
               if (m_pend[i]) m_ovf = 1'b1;
               m_pend[i] = 1'b1;
               m_rep[i]  = tk;
            end
         end
         m_prev = b;
      end
   endtask

   task automatic cycle(input logic [N-1:0] b, input bit r, input bit rs);
      bit exp_v;
      btn_n = b;
      evt_if.evt_ready = r;
      rst_n = rs;
      if (rs && evt_if.evt_valid === 1'b1 && r)
         got.push_back('{evt_if.evt_repeat, int'(evt_if.evt_code)});
      model_step(b, r, rs);
      @(posedge clk);
      #1;
      exp_v = (m_q.size() > 0);
      check_eq("evt_valid",  32'(evt_if.evt_valid),  32'(exp_v));
      check_eq("evt_code",   32'(evt_if.evt_code),   exp_v ? 32'(m_q[0].code) : 32'd0);
      check_eq("evt_repeat", 32'(evt_if.evt_repeat), exp_v ? 32'(m_q[0].rep)  : 32'd0);
      check_eq("ovf",        32'(ovf),               32'(m_ovf));
   endtask

   task automatic idle(input int n, input bit r);
      for (int k = 0; k < n; k++) cycle('1, r, 1'b1);
   endtask

   task automatic press_one(input int idx, input bit r);
      logic [N-1:0] b;
      b = '1;
      b[idx] = 1'b0;
      cycle(b, r, 1'b1);
      cycle('1, r, 1'b1);
   endtask

   function automatic int got_code(input int k);
      return (k < got.size()) ? got[k].code : -1;
   endfunction

   function automatic int got_reps();
      int n = 0;
      foreach (got[k]) if (got[k].rep) n++;
      return n;
   endfunction

   initial begin
      logic [N-1:0] rb;
      bit rr, rs;
      int rmode;

      cycle('1, 1'b0, 1'b0);
      cycle('1, 1'b0, 1'b0);
      check_eq("rst_valid", 32'(evt_if.evt_valid), 32'd0);
      check_eq("rst_ovf",   32'(ovf),              32'd0);
      idle(3, 1'b1);

      // Single press: valid rises two edges after the level change
      got.delete();
      cycle(5'b11011, 1'b1, 1'b1);
      check_eq("single_lat1", 32'(evt_if.evt_valid), 32'd0);
      cycle(5'b11011, 1'b1, 1'b1);
      check_eq("single_lat2", 32'(evt_if.evt_valid), 32'd1);
      check_eq("single_code", 32'(evt_if.evt_code),  32'd2);
      repeat (3) cycle(5'b11011, 1'b1, 1'b1);
      idle(5, 1'b1);
      check_eq("single_cnt", 32'(got.size()), 32'd1);
      check_eq("single_rep", 32'(got_reps()), 32'd0);

      // Simultaneous presses of 0, 3, 4
      got.delete();
      repeat (3) cycle(5'b00110, 1'b1, 1'b1);
      idle(5, 1'b1);
      check_eq("simul_cnt", 32'(got.size()), 32'd3);
      check_eq("simul_c0",  32'(got_code(0)), 32'd0);
      check_eq("simul_c1",  32'(got_code(1)), 32'd3);
      check_eq("simul_c2",  32'(got_code(2)), 32'd4);
      check_eq("simul_rep", 32'(got_reps()), 32'd0);
      check_eq("simul_ovf", 32'(ovf), 32'd0);

      // Button 1 held 50 cycles: one press, four repeats
      got.delete();
      repeat (50) cycle(5'b11101, 1'b1, 1'b1);
      idle(5, 1'b1);
      check_eq("hold_cnt",  32'(got.size()), 32'd5);
      check_eq("hold_reps", 32'(got_reps()), 32'd4);
      check_eq("hold_code", 32'(got_code(4)), 32'd1);

      // Second button joins at cycle 30: repeats stop
      got.delete();
      for (int k = 0; k < 50; k++) cycle((k < 30) ? 5'b11101 : 5'b01101, 1'b1, 1'b1);
      idle(5, 1'b1);
      check_eq("dual_cnt",  32'(got.size()), 32'd4);
      check_eq("dual_reps", 32'(got_reps()), 32'd2);
      check_eq("dual_last", 32'(got_code(3)), 32'd4);

      // Backpressure: four queued, button 4 staged, then merged
      got.delete();
      for (int i = 0; i < N; i++) begin
         press_one(i, 1'b0);
         cycle('1, 1'b0, 1'b1);
      end
      press_one(4, 1'b0);
      check_eq("bp_ovf", 32'(ovf), 32'd1);
      idle(8, 1'b1);
      check_eq("bp_cnt", 32'(got.size()), 32'd5);
      for (int i = 0; i < N; i++) check_eq("bp_order", 32'(got_code(i)), 32'(i));

      // Full FIFO with button 1 staged; a single pop frees one slot
      got.delete();
      press_one(0, 1'b0);
      press_one(2, 1'b0);
      press_one(3, 1'b0);
      press_one(4, 1'b0);
      press_one(1, 1'b0);
      idle(2, 1'b0);
      cycle('1, 1'b1, 1'b1);
      check_eq("fullpop_head", 32'(evt_if.evt_code), 32'd2);
      cycle('1, 1'b0, 1'b1);
      idle(8, 1'b1);
      check_eq("fullpop_cnt",  32'(got.size()), 32'd5);
      check_eq("fullpop_last", 32'(got_code(4)), 32'd1);

      // Reset mid-operation with button 2 held through it
      press_one(0, 1'b0);
      press_one(1, 1'b0);
      press_one(3, 1'b0);
      repeat (3) cycle(5'b11011, 1'b0, 1'b1);
      cycle(5'b11011, 1'b0, 1'b0);
      check_eq("midrst_valid", 32'(evt_if.evt_valid),  32'd0);
      check_eq("midrst_code",  32'(evt_if.evt_code),   32'd0);
      check_eq("midrst_rep",   32'(evt_if.evt_repeat), 32'd0);
      check_eq("midrst_ovf",   32'(ovf),               32'd0);
      got.delete();
      repeat (6) cycle(5'b11011, 1'b1, 1'b1);
      idle(5, 1'b1);
      check_eq("midrst_cnt",  32'(got.size()), 32'd1);
      check_eq("midrst_code2", 32'(got_code(0)), 32'd2);

      // Random traffic against the model
      rb = '1;
      rmode = 1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 23) == 0) begin
            case ($urandom_range(0, 3))
               0: rb = '1;
               1: begin rb = '1; rb[$urandom_range(0, N-1)] = 1'b0; end
               2: rb = N'($urandom);
               default: rb[$urandom_range(0, N-1)] = ~rb[$urandom_range(0, N-1)];
            endcase
         end
         if (c % 16 == 0) rmode = $urandom_range(0, 3);
         rr = (rmode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         rs = ($urandom_range(0, 999) != 0);
         cycle(rb, rr, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
